// File: rtl/axi_rd_pkg.sv
// Shared definitions for the AXI4 read-channel responder: burst and
// response encodings, the responder state type and a WRAP length check.
package axi_rd_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RESP
    } rd_state_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats
    function automatic logic is_valid_wrap_len(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst next-address calculator for FIXED, INCR and WRAP
// bursts. Shared by the read and write slave responders.
module axi_burst_addr_gen
    import axi_rd_pkg::*;
#(
    parameter int AW = 32
)(
    input  logic [AW-1:0] addr,
    input  logic [2:0]    size,
    input  logic [7:0]    len,
    input  logic [1:0]    burst,
    output logic [AW-1:0] next_addr
);

    logic [AW-1:0] incr;
    logic [AW-1:0] bound;
    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] sum;

    // Step by one beat; WRAP keeps the upper bits and wraps the low bits
    // inside the burst-sized window
    always_comb begin
        incr      = AW'(1) << size;
        bound     = AW'({1'b0, len} + 9'd1) << size;
        wrap_mask = bound - AW'(1);
        sum       = addr + incr;
        next_addr = addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = sum;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (sum & wrap_mask);
            default:     next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_read_slave_resp.sv
// AXI4 read-channel slave responder. Accepts one AR request at a time, walks
// the burst addresses, reads each beat from a 1-cycle-latency backend and
// returns R beats. Optional macro AXI_RD_BOUNDARY_CHECK_EN flags INCR bursts
// that cross a 4 KB boundary as bad.
module axi_read_slave_resp
    import axi_rd_pkg::*;
#(
    parameter int IDW = 12,
    parameter int AW  = 32,
    parameter int DW  = 64
)(
    input  logic           clk,
    input  logic           rst,
    input  logic [IDW-1:0] s_axi_arid,
    input  logic [AW-1:0]  s_axi_araddr,
    input  logic [7:0]     s_axi_arlen,
    input  logic [2:0]     s_axi_arsize,
    input  logic [1:0]     s_axi_arburst,
    input  logic           s_axi_arvalid,
    output logic           s_axi_arready,
    output logic [IDW-1:0] s_axi_rid,
    output logic [DW-1:0]  s_axi_rdata,
    output logic [1:0]     s_axi_rresp,
    output logic           s_axi_rlast,
    output logic           s_axi_rvalid,
    input  logic           s_axi_rready,
    output logic           mem_en,
    output logic [AW-1:0]  mem_addr,
    input  logic [DW-1:0]  mem_rdata,
    input  logic           mem_err
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DW / 8));

    rd_state_t      state, next_state;
    logic [IDW-1:0] id_q;
    logic [AW-1:0]  addr_q;
    logic [7:0]     len_q;
    logic [2:0]     size_q;
    logic [1:0]     burst_q;
    logic           bad_q;
    logic [7:0]     beat_cnt;
    logic           resp_first;
    logic [DW-1:0]  rdata_q;
    logic [1:0]     rresp_q;
    logic [AW-1:0]  next_addr;
    logic           bad_req;
    logic           boundary_bad;
    logic           last_beat;
    logic [DW-1:0]  rdata_now;
    logic [1:0]     rresp_now;

    axi_burst_addr_gen #(.AW(AW)) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

`ifdef AXI_RD_BOUNDARY_CHECK_EN
    logic [AW-1:0] last_addr;

    // An INCR burst whose final beat lands in a different 4 KB page is illegal
    always_comb begin
        last_addr    = s_axi_araddr + (AW'(s_axi_arlen) << s_axi_arsize);
        boundary_bad = (s_axi_arburst == BURST_INCR) &&
                       (last_addr[AW-1:12] != s_axi_araddr[AW-1:12]);
    end
`else
    assign boundary_bad = 1'b0;
`endif

    // Classify the incoming request; a bad request is answered with SLVERR beats only
    always_comb begin
        bad_req = boundary_bad;
        if (s_axi_arburst == 2'b11) bad_req = 1'b1;
        if ((s_axi_arburst == BURST_WRAP) && !is_valid_wrap_len(s_axi_arlen)) bad_req = 1'b1;
        if (s_axi_arsize > MAX_SIZE) bad_req = 1'b1;
    end

    assign last_beat = (beat_cnt == len_q);

    // Backend data arrives in the first RESP cycle; it is shown directly then and
    // held from the capture register while the master stalls
    assign rdata_now   = bad_q ? '0 : mem_rdata;
    assign rresp_now   = (bad_q || mem_err) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rdata = resp_first ? rdata_now : rdata_q;
    assign s_axi_rresp = resp_first ? rresp_now : rresp_q;
    assign s_axi_rid   = id_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and handshake/backend strobes
    always_comb begin
        next_state    = state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        mem_en        = 1'b0;
        mem_addr      = '0;
        case (state)
            IDLE: begin
                s_axi_arready = !rst;
                if (s_axi_arvalid) next_state = FETCH;
            end
            FETCH: begin
                mem_en     = !bad_q;
                mem_addr   = bad_q ? '0 : addr_q;
                next_state = RESP;
            end
            RESP: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = last_beat;
                if (s_axi_rready) next_state = last_beat ? IDLE : FETCH;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latch, beat walking and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            bad_q      <= 1'b0;
            beat_cnt   <= '0;
            resp_first <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            resp_first <= (state == FETCH);
            if ((state == IDLE) && s_axi_arvalid) begin
                id_q     <= s_axi_arid;
                addr_q   <= s_axi_araddr;
                len_q    <= s_axi_arlen;
                size_q   <= s_axi_arsize;
                burst_q  <= s_axi_arburst;
                bad_q    <= bad_req;
                beat_cnt <= '0;
            end
            if (resp_first) begin
                rdata_q <= rdata_now;
                rresp_q <= rresp_now;
            end
            if ((state == RESP) && s_axi_rready && !last_beat) begin
                addr_q   <= next_addr;
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_slave_resp.sv
// Directed self-checking bench for axi_read_slave_resp with a small
// 1-cycle-latency backend memory model.
module tb_axi_read_slave_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [11:0] rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [63:0] mem_rdata = '0;
    logic        mem_err = 1'b0;

    int checks = 0;
    int fails = 0;
    int err_beat = -1;
    int model_cnt = 0;

    // Observations collected by do_burst
    int          n_mem, n_beats, first_mem_k, first_rv_k, done_k, ar_busy;
    bit          timed_out;
    logic        arready_after, rvalid_after, ar_accept_obs;
    logic [31:0] mem_addrs [16];
    logic [63:0] b_data [16];
    logic [1:0]  b_resp [16];
    logic        b_last [16];
    logic [11:0] b_id [16];
    logic [63:0] pre_data [16];
    logic [1:0]  pre_resp [16];
    logic        pre_last [16];

    axi_read_slave_resp #(.IDW(12), .AW(32), .DW(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_arid    (arid),
        .s_axi_araddr  (araddr),
        .s_axi_arlen   (arlen),
        .s_axi_arsize  (arsize),
        .s_axi_arburst (arburst),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rid     (rid),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rlast   (rlast),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mdata(input logic [31:0] a);
        return {~a, a};
    endfunction

    // Backend: data for a strobed address appears the following cycle; garbage otherwise
    always @(posedge clk) begin
        if (arvalid && arready) begin
            model_cnt <= 0;
        end else if (mem_en) begin
            mem_rdata <= mdata(mem_addr);
            mem_err   <= (model_cnt == err_beat);
            model_cnt <= model_cnt + 1;
        end else begin
            mem_rdata <= 64'hDEAD_BEEF_DEAD_BEEF;
            mem_err   <= 1'b1;
        end
    end

    task automatic do_burst(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit toggle);
        int  k;
        bit  done, pending, phase;
        n_mem = 0; n_beats = 0; first_mem_k = -1; first_rv_k = -1; done_k = -1; ar_busy = 0;
        timed_out = 0; done = 0; pending = 0; phase = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        ar_accept_obs = arready;
        @(posedge clk); #1;
        arvalid = 1'b0;
        k = 1;
        while (!done && k < 200) begin
            if (arready) ar_busy++;
            if (mem_en) begin
                if (n_mem < 16) mem_addrs[n_mem] = mem_addr;
                n_mem++;
                if (first_mem_k < 0) first_mem_k = k;
            end
            if (rvalid) begin
                if (first_rv_k < 0) first_rv_k = k;
                if (!pending && n_beats < 16) begin
                    pre_data[n_beats] = rdata; pre_resp[n_beats] = rresp; pre_last[n_beats] = rlast;
                end
                rready = toggle ? phase : 1'b1;
                if (toggle) phase = !phase;
                if (rready) begin
                    if (n_beats < 16) begin
                        b_data[n_beats] = rdata; b_resp[n_beats] = rresp;
                        b_last[n_beats] = rlast; b_id[n_beats] = rid;
                    end
                    n_beats++;
                    pending = 0;
                    if (rlast) begin done = 1; done_k = k; end
                end else begin
                    pending = 1;
                end
            end else begin
                rready = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        rready = 1'b0;
        if (!done) timed_out = 1;
        arready_after = arready;
        rvalid_after  = rvalid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (arready !== 1'b0) begin fails++; $display("[TB] FAIL reset_arready: got %b expected 0", arready); end
        checks++; if ({rvalid, rlast, mem_en} !== 3'b000) begin fails++; $display("[TB] FAIL reset_strobes: got %b expected 000", {rvalid, rlast, mem_en}); end
        checks++; if (rresp !== 2'b00 || rdata !== 64'd0 || rid !== 12'd0 || mem_addr !== 32'd0) begin
            fails++; $display("[TB] FAIL reset_values: got resp=%h data=%h id=%h maddr=%h expected all 0", rresp, rdata, rid, mem_addr);
        end
        rst = 1'b0;
        #1;
        checks++; if (arready !== 1'b1) begin fails++; $display("[TB] FAIL reset_idle_arready: got %b expected 1", arready); end
        @(posedge clk); #1;
    endtask

    task automatic test_incr();
        logic [31:0] exp_a [4] = '{32'h100, 32'h108, 32'h110, 32'h118};
        err_beat = -1;
        do_burst(12'h123, 32'h100, 8'd3, 3'd3, 2'b01, 1'b0);
        checks++; if (timed_out) begin fails++; $display("[TB] FAIL incr_timeout: got timeout expected completion"); end
        checks++; if (ar_accept_obs !== 1'b1) begin fails++; $display("[TB] FAIL incr_ar_accept: got %b expected 1", ar_accept_obs); end
        checks++; if (n_mem != 4 || n_beats != 4) begin fails++; $display("[TB] FAIL incr_counts: got mem=%0d beats=%0d expected 4/4", n_mem, n_beats); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_addrs[i] !== exp_a[i]) begin fails++; $display("[TB] FAIL incr_maddr%0d: got %h expected %h", i, mem_addrs[i], exp_a[i]); end
            checks++; if (b_data[i] !== mdata(exp_a[i]) || b_resp[i] !== 2'b00 || b_last[i] !== (i == 3) || b_id[i] !== 12'h123) begin
                fails++; $display("[TB] FAIL incr_beat%0d: got data=%h resp=%b last=%b id=%h expected %h/00/%0d/123", i, b_data[i], b_resp[i], b_last[i], b_id[i], mdata(exp_a[i]), (i == 3));
            end
        end
        checks++; if (first_mem_k != 1 || first_rv_k != 2) begin fails++; $display("[TB] FAIL incr_latency: got mem_en@%0d rvalid@%0d expected 1/2", first_mem_k, first_rv_k); end
        checks++; if (done_k != 8) begin fails++; $display("[TB] FAIL incr_throughput: got last beat@%0d expected 8", done_k); end
        checks++; if (ar_busy != 0) begin fails++; $display("[TB] FAIL incr_arready_busy: got %0d high cycles expected 0", ar_busy); end
        checks++; if (arready_after !== 1'b1 || rvalid_after !== 1'b0) begin fails++; $display("[TB] FAIL incr_after: got arready=%b rvalid=%b expected 1/0", arready_after, rvalid_after); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [4] = '{32'h38, 32'h20, 32'h28, 32'h30};
        err_beat = -1;
        do_burst(12'hABC, 32'h38, 8'd3, 3'd3, 2'b10, 1'b0);
        checks++; if (timed_out || n_mem != 4 || n_beats != 4) begin fails++; $display("[TB] FAIL wrap_counts: got to=%0d mem=%0d beats=%0d expected 0/4/4", timed_out, n_mem, n_beats); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_addrs[i] !== exp_a[i]) begin fails++; $display("[TB] FAIL wrap_maddr%0d: got %h expected %h", i, mem_addrs[i], exp_a[i]); end
            checks++; if (b_id[i] !== 12'hABC || b_data[i] !== mdata(exp_a[i])) begin fails++; $display("[TB] FAIL wrap_beat%0d: got id=%h data=%h expected ABC/%h", i, b_id[i], b_data[i], mdata(exp_a[i])); end
        end
    endtask

    task automatic test_fixed_stall();
        err_beat = -1;
        do_burst(12'h011, 32'h40, 8'd2, 3'd3, 2'b00, 1'b1);
        checks++; if (timed_out || n_mem != 3 || n_beats != 3) begin fails++; $display("[TB] FAIL fixed_counts: got to=%0d mem=%0d beats=%0d expected 0/3/3", timed_out, n_mem, n_beats); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_addrs[i] !== 32'h40) begin fails++; $display("[TB] FAIL fixed_maddr%0d: got %h expected 40", i, mem_addrs[i]); end
            checks++; if (b_data[i] !== mdata(32'h40) || b_resp[i] !== 2'b00 || b_last[i] !== (i == 2)) begin
                fails++; $display("[TB] FAIL fixed_beat%0d: got data=%h resp=%b last=%b expected %h/00/%0d", i, b_data[i], b_resp[i], b_last[i], mdata(32'h40), (i == 2));
            end
            checks++; if (pre_data[i] !== mdata(32'h40) || pre_resp[i] !== 2'b00 || pre_last[i] !== (i == 2)) begin
                fails++; $display("[TB] FAIL fixed_stall%0d: got data=%h resp=%b last=%b before stall expected %h/00/%0d", i, pre_data[i], pre_resp[i], pre_last[i], mdata(32'h40), (i == 2));
            end
        end
    endtask

    task automatic test_bad_request();
        err_beat = -1;
        do_burst(12'h0B1, 32'h80, 8'd1, 3'd3, 2'b11, 1'b0);
        checks++; if (timed_out || n_mem != 0 || n_beats != 2) begin fails++; $display("[TB] FAIL bad_rsvd_counts: got to=%0d mem=%0d beats=%0d expected 0/0/2", timed_out, n_mem, n_beats); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (b_resp[i] !== 2'b10 || b_data[i] !== 64'd0 || b_last[i] !== (i == 1)) begin
                fails++; $display("[TB] FAIL bad_rsvd_beat%0d: got resp=%b data=%h last=%b expected 10/0/%0d", i, b_resp[i], b_data[i], b_last[i], (i == 1));
            end
        end
        do_burst(12'h0B2, 32'h80, 8'd2, 3'd3, 2'b10, 1'b0);
        checks++; if (timed_out || n_mem != 0 || n_beats != 3) begin fails++; $display("[TB] FAIL bad_wrap_counts: got to=%0d mem=%0d beats=%0d expected 0/0/3", timed_out, n_mem, n_beats); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (b_resp[i] !== 2'b10 || b_data[i] !== 64'd0 || b_last[i] !== (i == 2)) begin
                fails++; $display("[TB] FAIL bad_wrap_beat%0d: got resp=%b data=%h last=%b expected 10/0/%0d", i, b_resp[i], b_data[i], b_last[i], (i == 2));
            end
        end
        do_burst(12'h0B3, 32'h0, 8'd0, 3'd4, 2'b01, 1'b0);
        checks++; if (timed_out || n_mem != 0 || n_beats != 1 || b_resp[0] !== 2'b10 || b_last[0] !== 1'b1) begin
            fails++; $display("[TB] FAIL bad_size: got to=%0d mem=%0d beats=%0d resp=%b last=%b expected 0/0/1/10/1", timed_out, n_mem, n_beats, b_resp[0], b_last[0]);
        end
    endtask

    task automatic test_mem_err();
        logic [1:0] exp_r [4] = '{2'b00, 2'b10, 2'b00, 2'b00};
        err_beat = 1;
        do_burst(12'h0E0, 32'h200, 8'd3, 3'd3, 2'b01, 1'b0);
        err_beat = -1;
        checks++; if (timed_out || n_beats != 4) begin fails++; $display("[TB] FAIL memerr_counts: got to=%0d beats=%0d expected 0/4", timed_out, n_beats); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (b_resp[i] !== exp_r[i]) begin fails++; $display("[TB] FAIL memerr_resp%0d: got %b expected %b", i, b_resp[i], exp_r[i]); end
        end
    endtask

    task automatic test_len0_unaligned();
        err_beat = -1;
        do_burst(12'h005, 32'h13, 8'd0, 3'd2, 2'b01, 1'b0);
        checks++; if (timed_out || n_mem != 1 || n_beats != 1) begin fails++; $display("[TB] FAIL len0_counts: got to=%0d mem=%0d beats=%0d expected 0/1/1", timed_out, n_mem, n_beats); end
        checks++; if (mem_addrs[0] !== 32'h13 || b_last[0] !== 1'b1 || b_data[0] !== mdata(32'h13)) begin
            fails++; $display("[TB] FAIL len0_beat: got maddr=%h last=%b data=%h expected 13/1/%h", mem_addrs[0], b_last[0], b_data[0], mdata(32'h13));
        end
    endtask

    task automatic test_boundary();
        err_beat = -1;
        do_burst(12'h0F0, 32'hFF8, 8'd1, 3'd3, 2'b01, 1'b0);
        checks++; if (timed_out || n_beats != 2) begin fails++; $display("[TB] FAIL bound_counts: got to=%0d beats=%0d expected 0/2", timed_out, n_beats); end
`ifdef AXI_RD_BOUNDARY_CHECK_EN
        checks++; if (n_mem != 0 || b_resp[0] !== 2'b10 || b_resp[1] !== 2'b10) begin
            fails++; $display("[TB] FAIL bound_slverr: got mem=%0d resp=%b,%b expected 0/10,10", n_mem, b_resp[0], b_resp[1]);
        end
`else
        checks++; if (n_mem != 2 || mem_addrs[1] !== 32'h1000 || b_resp[0] !== 2'b00 || b_resp[1] !== 2'b00) begin
            fails++; $display("[TB] FAIL bound_cross: got mem=%0d maddr1=%h resp=%b,%b expected 2/1000/00,00", n_mem, mem_addrs[1], b_resp[0], b_resp[1]);
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        int seen_rv, seen_me;
        bit found;
        err_beat = -1;
        arid = 12'h777; araddr = 32'h300; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        rready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (rvalid) found = 1;
            else begin @(posedge clk); #1; end
        end
        checks++; if (!found) begin fails++; $display("[TB] FAIL midrst_reach_resp: got no rvalid expected rvalid within 10 cycles"); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (rvalid !== 1'b0 || arready !== 1'b1 || mem_en !== 1'b0) begin
            fails++; $display("[TB] FAIL midrst_after: got rvalid=%b arready=%b mem_en=%b expected 0/1/0", rvalid, arready, mem_en);
        end
        rready = 1'b1;
        seen_rv = 0; seen_me = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (rvalid) seen_rv++;
            if (mem_en) seen_me++;
        end
        rready = 1'b0;
        checks++; if (seen_rv != 0 || seen_me != 0) begin fails++; $display("[TB] FAIL midrst_quiet: got rvalid=%0d mem_en=%0d cycles expected 0/0", seen_rv, seen_me); end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed_stall();
        test_bad_request();
        test_mem_err();
        test_len0_unaligned();
        test_boundary();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
